// File: rtl/bus_drive_arbiter_pkg.sv
// Shared definitions for the tri-state bus arbiter: FSM states and the
// high-Z control polarity of the downstream bus buffers.
package bus_drive_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } arb_state_t;

    // Buffer switch polarity: a 1 on the control pin floats the output.
    localparam logic HIZ_ON  = 1'b1;
    localparam logic HIZ_OFF = 1'b0;

endpackage

// File: rtl/bus_drive_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req bit at or after 'start',
// wrapping modulo NREQ. NREQ need not be a power of two.
module rr_pick #(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  start,
    output logic [NREQ-1:0] winner,
    output logic [IDW-1:0]  winner_id,
    output logic            any_req
);

    always_comb begin
        logic           found;
        int unsigned    cand;
        logic [IDW-1:0] idx;
        winner    = '0;
        winner_id = '0;
        any_req   = |req;
        found     = 1'b0;
        cand      = 0;
        idx       = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = int'(start) + i;
            if (cand >= NREQ)
                cand = cand - NREQ;
            idx = IDW'(cand);
            if (!found && req[idx]) begin
                found          = 1'b1;
                winner[idx]    = 1'b1;
                winner_id      = idx;
            end
        end
    end

endmodule

// File: rtl/bus_drive_arbiter.sv
// Round-robin owner of a shared tri-state bus with bounded hold time and a
// one-cycle all-Z turnaround between owners. All outputs are registered.
module bus_drive_arbiter
    import bus_drive_arbiter_pkg::*;
#(
    parameter  int unsigned NREQ     = 4,
    parameter  int unsigned MAX_HOLD = 8,
    localparam int unsigned IDW      = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic [NREQ-1:0] hiz,
    output logic [IDW-1:0]  owner_id,
    output logic            bus_busy
);

    localparam int unsigned HCW = $clog2(MAX_HOLD);
    localparam logic [HCW-1:0] HOLD_MAX = HCW'(MAX_HOLD - 1);

    arb_state_t      state;
    logic [HCW-1:0]  hold_cnt;
    logic [IDW-1:0]  start_id;
    logic [NREQ-1:0] pick;
    logic [IDW-1:0]  pick_id;
    logic            any_req;
    logic            owner_req;
    logic            others_pending;
    logic            release_bus;

    // Search begins just past the current/last owner, so a previous owner
    // only wins again when nobody else is asking.
    always_comb begin
        start_id = (owner_id == IDW'(NREQ - 1)) ? '0 : owner_id + 1'b1;
    end

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req       (req),
        .start     (start_id),
        .winner    (pick),
        .winner_id (pick_id),
        .any_req   (any_req)
    );

    always_comb begin
        owner_req      = |(req & grant);
        others_pending = |(req & ~grant);
        release_bus    = !owner_req || (hold_cnt == HOLD_MAX && others_pending);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= '0;
            hiz      <= {NREQ{HIZ_ON}};
            owner_id <= IDW'(NREQ - 1);
            bus_busy <= 1'b0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE, TURN: begin
                    if (any_req) begin
                        state    <= OWN;
                        grant    <= pick;
                        hiz      <= ~pick;
                        owner_id <= pick_id;
                        bus_busy <= 1'b1;
                        hold_cnt <= '0;
                    end else begin
                        state    <= IDLE;
                        grant    <= '0;
                        hiz      <= {NREQ{HIZ_ON}};
                        bus_busy <= 1'b0;
                    end
                end
                OWN: begin
                    if (release_bus) begin
                        state    <= TURN;
                        grant    <= '0;
                        hiz      <= {NREQ{HIZ_ON}};
                        bus_busy <= 1'b0;
                    end else if (hold_cnt != HOLD_MAX) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    grant    <= '0;
                    hiz      <= {NREQ{HIZ_ON}};
                    bus_busy <= 1'b0;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

endmodule
